// File: rtl/vote_tally_seq.sv
// Serial ballot collector: opens a voting session, tallies yes/no per voter, and reports a
// threshold decision on close, timeout or all-voted. Optional early close: VOTE_TALLY_EARLY_DECIDE_EN.
module vote_tally_seq #(
    parameter int unsigned N_VOTERS = 8,
    parameter int unsigned THRESH   = 4,
    parameter int unsigned WINDOW   = 16,
    localparam int unsigned ID_W    = $clog2(N_VOTERS),
    localparam int unsigned CNT_W   = $clog2(N_VOTERS + 1),
    localparam int unsigned TMR_W   = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ballot_valid,
    input  logic [ID_W-1:0]  ballot_id,
    input  logic             ballot_yes,
    input  logic             close,
    output logic             busy,
    output logic             ballot_err,
    output logic             result_valid,
    output logic             result_pass,
    output logic [CNT_W-1:0] yes_count,
    output logic [CNT_W-1:0] no_count
);

    localparam int unsigned ID_XW  = ID_W + 1;
    localparam int unsigned CNT_XW = CNT_W + 1;
    localparam int unsigned MASK_W = 1 << ID_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OPEN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt_c;
    logic [MASK_W-1:0] mask;
    logic [TMR_W-1:0]  timer;
    logic              in_range_c;
    logic              accept_c;
    logic [CNT_XW-1:0] yes_post_c;
    logic [CNT_XW-1:0] no_post_c;
    logic              all_voted_c;
    logic              timeout_c;
    logic              early_c;

    // Tallies as they will stand after this edge's ballot, if accepted
    assign in_range_c  = {1'b0, ballot_id} < ID_XW'(N_VOTERS);
    assign accept_c    = (state == S_OPEN) && ballot_valid && in_range_c && !mask[ballot_id];
    assign yes_post_c  = {1'b0, yes_count} + CNT_XW'(accept_c && ballot_yes);
    assign no_post_c   = {1'b0, no_count} + CNT_XW'(accept_c && !ballot_yes);
    assign all_voted_c = (yes_post_c + no_post_c) == CNT_XW'(N_VOTERS);
    assign timeout_c   = timer == TMR_W'(WINDOW - 1);

`ifdef VOTE_TALLY_EARLY_DECIDE_EN
    // Outcome is settled once pass is reached or the remaining voters cannot reach it
    assign early_c = (yes_post_c >= CNT_XW'(THRESH)) ||
                     ((CNT_XW'(N_VOTERS) - no_post_c) < CNT_XW'(THRESH));
`else
    assign early_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt_c;
        end
    end

    always_comb begin
        state_nxt_c = state;
        case (state)
            S_IDLE:  if (start) state_nxt_c = S_OPEN;
            S_OPEN:  if (close || timeout_c || all_voted_c || early_c) state_nxt_c = S_DONE;
            S_DONE:  state_nxt_c = S_IDLE;
            default: state_nxt_c = S_IDLE;
        endcase
    end

    // Session datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            ballot_err   <= 1'b0;
            result_valid <= 1'b0;
            result_pass  <= 1'b0;
            yes_count    <= '0;
            no_count     <= '0;
            mask         <= '0;
            timer        <= '0;
        end else begin
            busy         <= state_nxt_c != S_IDLE;
            result_valid <= state_nxt_c == S_DONE;
            ballot_err   <= ballot_valid && !accept_c;
            if (state == S_IDLE && start) begin
                mask        <= '0;
                timer       <= '0;
                yes_count   <= '0;
                no_count    <= '0;
                result_pass <= 1'b0;
            end else if (state == S_OPEN) begin
                timer     <= timer + TMR_W'(1);
                yes_count <= yes_post_c[CNT_W-1:0];
                no_count  <= no_post_c[CNT_W-1:0];
                if (accept_c) begin
                    mask[ballot_id] <= 1'b1;
                end
                if (state_nxt_c == S_DONE) begin
                    result_pass <= yes_post_c >= CNT_XW'(THRESH);
                end
            end
        end
    end

endmodule

// File: tb/tb_vote_tally_seq.sv
// Directed bench for vote_tally_seq (default build): expected results are queued when a
// session is driven and compared when result_valid pulses.
module tb_vote_tally_seq;

    localparam int unsigned N_VOTERS = 8;
    localparam int unsigned THRESH   = 4;
    localparam int unsigned WINDOW   = 16;

    typedef struct packed {
        logic       pass;
        logic [3:0] yes;
        logic [3:0] no;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ballot_valid;
    logic [2:0] ballot_id;
    logic       ballot_yes;
    logic       close;
    logic       busy;
    logic       ballot_err;
    logic       result_valid;
    logic       result_pass;
    logic [3:0] yes_count;
    logic [3:0] no_count;

    res_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   last_wait = 0;

    vote_tally_seq #(.N_VOTERS(N_VOTERS), .THRESH(THRESH), .WINDOW(WINDOW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ballot_valid (ballot_valid),
        .ballot_id    (ballot_id),
        .ballot_yes   (ballot_yes),
        .close        (close),
        .busy         (busy),
        .ballot_err   (ballot_err),
        .result_valid (result_valid),
        .result_pass  (result_pass),
        .yes_count    (yes_count),
        .no_count     (no_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic ballot(input logic [2:0] id, input logic yes);
        ballot_valid = 1'b1;
        ballot_id    = id;
        ballot_yes   = yes;
        @(negedge clk);
        ballot_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_close();
        close = 1'b1;
        @(negedge clk);
        close = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Wait (bounded) for the result pulse, pop the scoreboard and compare, then check the pulse ends
    task automatic wait_result(input string tag, input int budget);
        res_t e;
        int   waited;
        waited = 0;
        while (result_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        e = (sb.size() > 0) ? sb.pop_front() : '1;
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_pass"},  32'(result_pass),  32'(e.pass));
        check({tag, "_yes"},   32'(yes_count),    32'(e.yes));
        check({tag, "_no"},    32'(no_count),     32'(e.no));
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(result_valid), 32'd0);
        check({tag, "_busy_end"},  32'(busy),         32'd0);
        check({tag, "_yes_held"},  32'(yes_count),    32'(e.yes));
    endtask

    initial begin
        logic seen_rv;
        rst_n        = 1'b0;
        start        = 1'b0;
        ballot_valid = 1'b0;
        ballot_id    = 3'd0;
        ballot_yes   = 1'b0;
        close        = 1'b0;
        idle(2);
        check("rst_busy",   32'(busy),         32'd0);
        check("rst_err",    32'(ballot_err),   32'd0);
        check("rst_rv",     32'(result_valid), 32'd0);
        check("rst_pass",   32'(result_pass),  32'd0);
        check("rst_yes",    32'(yes_count),    32'd0);
        check("rst_no",     32'(no_count),     32'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: full turnout, exactly at threshold
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        sb.push_back('{pass: 1'b1, yes: 4'd4, no: 4'd4});
        for (int i = 0; i < 4; i++) ballot(3'(i), 1'b1);
        for (int i = 4; i < 8; i++) ballot(3'(i), 1'b0);
        wait_result("t1", 10);
        check("t1_latency", 32'(last_wait), 32'd0);

        // 2: timeout after WINDOW open cycles
        pulse_start();
        sb.push_back('{pass: 1'b0, yes: 4'd3, no: 4'd0});
        for (int i = 0; i < 3; i++) ballot(3'(i), 1'b1);
        check("t2_open_rv", 32'(result_valid), 32'd0);
        wait_result("t2", 30);
        check("t2_latency", 32'(last_wait), 32'(WINDOW - 3));

        // 3: duplicate ballot, then ballot together with close
        pulse_start();
        ballot(3'd2, 1'b1);
        check("t3_first_err", 32'(ballot_err), 32'd0);
        ballot(3'd2, 1'b1);
        check("t3_dup_err", 32'(ballot_err), 32'd1);
        check("t3_dup_yes", 32'(yes_count),  32'd1);
        sb.push_back('{pass: 1'b0, yes: 4'd1, no: 4'd1});
        ballot_valid = 1'b1;
        ballot_id    = 3'd3;
        ballot_yes   = 1'b0;
        close        = 1'b1;
        @(negedge clk);
        ballot_valid = 1'b0;
        close        = 1'b0;
        check("t3_close_err", 32'(ballot_err), 32'd0);
        wait_result("t3", 5);

        // 4: ballot in IDLE, start+ballot in IDLE, start while OPEN
        ballot(3'd5, 1'b1);
        check("t4_idle_err",  32'(ballot_err), 32'd1);
        check("t4_idle_busy", 32'(busy),       32'd0);
        check("t4_idle_yes",  32'(yes_count),  32'd1);
        start        = 1'b1;
        ballot_valid = 1'b1;
        ballot_id    = 3'd5;
        ballot_yes   = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        ballot_valid = 1'b0;
        check("t4_sb_err",  32'(ballot_err), 32'd1);
        check("t4_sb_busy", 32'(busy),       32'd1);
        check("t4_sb_yes",  32'(yes_count),  32'd0);
        ballot(3'd0, 1'b1);
        pulse_start();
        check("t4_restart_busy", 32'(busy),      32'd1);
        check("t4_restart_yes",  32'(yes_count), 32'd1);
        check("t4_restart_rv",   32'(result_valid), 32'd0);
        sb.push_back('{pass: 1'b0, yes: 4'd1, no: 4'd0});
        pulse_close();
        wait_result("t4", 5);

        // 5: reset mid-session aborts it
        pulse_start();
        ballot(3'd0, 1'b1);
        ballot(3'd1, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_busy", 32'(busy),         32'd0);
        check("t5_rv",   32'(result_valid), 32'd0);
        check("t5_yes",  32'(yes_count),    32'd0);
        check("t5_pass", 32'(result_pass),  32'd0);
        seen_rv = 1'b0;
        for (int i = 0; i < WINDOW + 4; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen_rv = 1'b1;
        end
        check("t5_no_result", 32'(seen_rv), 32'd0);
        pulse_start();
        ballot(3'd1, 1'b1);
        check("t5_new_err", 32'(ballot_err), 32'd0);
        check("t5_new_yes", 32'(yes_count),  32'd1);
        sb.push_back('{pass: 1'b0, yes: 4'd1, no: 4'd0});
        pulse_close();
        wait_result("t5", 5);

        // 6: reaching the threshold does not close the session in the default build
        pulse_start();
        for (int i = 0; i < 4; i++) ballot(3'(i), 1'b1);
        idle(3);
        check("t6_busy", 32'(busy),         32'd1);
        check("t6_rv",   32'(result_valid), 32'd0);
        sb.push_back('{pass: 1'b1, yes: 4'd4, no: 4'd0});
        pulse_close();
        wait_result("t6", 5);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
